vga_text_display: RTL and testbench
===================================

# vga_text_display

Downstream consumer of the 40x30-character screen memory. Generates 640x480@60 Hz VGA timing from the system clock and converts each pixel position into a screen-memory address. It looks the character code up in the glyph bitmap memory and drives registered RGB and sync outputs to the VGA connector. Both memories are read combinationally, with data valid in the same cycle as the address.

## Interface
- CLKS_PER_PIXEL, 4: system clocks per pixel (100 MHz clock gives a 25 MHz pixel rate); must be ≥1.
- H_VISIBLE/H_FRONT/H_SYNC/H_BACK, 640/16/96/48: horizontal timing in pixels (total 800).
- V_VISIBLE/V_FRONT/V_SYNC/V_BACK, 480/10/2/33: vertical timing in lines (total 525).
- COLS, 40: characters per row. Characters are fixed at 16x16 pixels, giving 30 rows.
- clock  in  1  system clock; everything updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- smem_addr  out  11  screen-memory address, 0..1199.
- smem_data  in  8  character code read from screen memory.
- bmem_addr  out  16  glyph-memory address {code[7:0], yoff[3:0], xoff[3:0]}.
- bmem_data  in  12  glyph pixel colour {r[3:0], g[3:0], b[3:0]}.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- red, green, blue  out  4 each  pixel colour; 0 during blanking.
- frame_start  out  1  one-clock pulse marking the first visible pixel of each frame.

## Operation
- **Pixel enable.** A divider counts 0..CLKS_PER_PIXEL-1 and wraps. `pix_en` is high in the cycle where the divider equals CLKS_PER_PIXEL-1. All state below advances only on clocks where `pix_en` is high.
- **Position counters (stage 0).**
  - x counts 0..799, then wraps to 0.
  - y increments only when x wraps, counts 0..524, then wraps to 0.
- **Screen-memory address.** Combinational from stage 0:
  - Visible region (x<640 and y<480): smem_addr = (y>>4)*40 + (x>>4). The multiply is done as (row<<5)+(row<<3) in 11 bits, with no overflow since the maximum is 1199.
  - Outside the visible region: smem_addr = 0.
- **Stage 1 registers.** Capture code=smem_data, xoff=x[3:0], yoff=y[3:0], active=(x<640 and y<480), and the raw syncs:
  - hs = !(656 ≤ x < 752)
  - vs = !(490 ≤ y < 492)
- **Glyph address.** bmem_addr = {code, yoff, xoff}, combinational from stage 1.
- **Stage 2 registers (the outputs).**
  - {red, green, blue} = active ? bmem_data : 0.
  - hsync/vsync take stage 1 hs/vs, so syncs stay aligned with colour.
- **frame_start.** High for exactly one clock: the clock after stage 2 loads the pixel from x=0, y=0. Low at all other times.

## Timing
- **Reset.** Asserting reset immediately (asynchronously) forces:
  - divider=0, x=0, y=0;
  - stage 1 active=0, hs=vs=1, code=0, xoff=yoff=0;
  - hsync=1, vsync=1, RGB=0, frame_start=0;
  - therefore smem_addr=0 and bmem_addr=0.
- **First pixel after reset.** After reset deasserts, the first `pix_en` occurs on clock edge CLKS_PER_PIXEL.
- **Latency.** Outputs lag the stage 0 counters by exactly 2 pixel periods (2*CLKS_PER_PIXEL clocks). Outputs are stable between pixel enables.
- **Line period.** 800 pixels = 3200 clocks. hsync is low for 96 pixels = 384 clocks, beginning 656 pixels after the first visible pixel of the line.
- **Frame period.** 525 lines = 1,680,000 clocks. vsync is low for 2 lines, over lines 490–491.
- **Wrap-around.**
  - x=799 with `pix_en` gives x=0 and y+1 in the same edge.
  - x=799, y=524 wraps both counters to 0.
- **Reset mid-frame.** The frame is abandoned with no partial output. Timing restarts from (0,0).
- **Input timing.** The block never gates on memory readiness. Memory data must be valid within the clock in which its address is presented.

## Test plan
- **Async reset.** Assert reset mid-line with no clock edge. Required: hsync=1, vsync=1, RGB=0, smem_addr=0, frame_start=0 immediately. After release, the first `pix_en` arrives on the 4th clock edge.
- **Line timing.** Free-run with CLKS_PER_PIXEL=4. Required: hsync falling edges 3200 clocks apart; hsync low for exactly 384 clocks.
- **Frame timing.** Free-run for two frames. Required: vsync low for 6400 clocks; vsync falling edges 1,680,000 clocks apart; frame_start pulses 1,680,000 clocks apart, each 1 clock wide.
- **Addressing.** Check smem_addr against stage 0 position:
  - x=17, y=35 → smem_addr=81.
  - x=639, y=479 → smem_addr=1199.
  - x=640, y=0 → smem_addr=0.
  - x=0, y=480 → smem_addr=0.
- **Pipeline.** Screen-memory model holds location 81 = 0x41. The glyph model returns 0xABC at address 0x4131 and 0x000 elsewhere. Required:
  - bmem_addr=0x4131 one pixel after the counters reach (17,35).
  - {red, green, blue} = A/B/C two pixels after the counters reach (17,35), with hsync/vsync matching the stage 0 values of that same position.
- **Blanking.** Glyph model returns 0xFFF everywhere. Required: RGB=0 for all outputs whose source x≥640 or y≥480; RGB=0xFFF for all visible pixels.

Source files
------------

// File: rtl/vga_text_display.sv
// vga_text_display: VGA timing generator and text-mode renderer.
// Screen memory is indexed by character cell and glyph memory by {code, yoff, xoff}.
// Each pixel passes through two pipeline stages before it reaches the outputs.
module vga_text_display #(
  parameter int unsigned CLKS_PER_PIXEL = 4,
  parameter int unsigned H_VISIBLE      = 640,
  parameter int unsigned H_FRONT        = 16,
  parameter int unsigned H_SYNC         = 96,
  parameter int unsigned H_BACK         = 48,
  parameter int unsigned V_VISIBLE      = 480,
  parameter int unsigned V_FRONT        = 10,
  parameter int unsigned V_SYNC         = 2,
  parameter int unsigned V_BACK         = 33,
  parameter int unsigned COLS           = 40
) (
  input  logic        clock,
  input  logic        reset,
  output logic [10:0] smem_addr,
  input  logic [7:0]  smem_data,
  output logic [15:0] bmem_addr,
  input  logic [11:0] bmem_data,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned XW       = $clog2(H_TOTAL);
  localparam int unsigned YW       = $clog2(V_TOTAL);
  localparam int unsigned DW       = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [DW-1:0] div;
  logic          pix_en;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          vis0;
  logic          hs0;
  logic          vs0;
  logic          first0;
  logic [10:0]   row;
  logic [10:0]   col;
  logic [7:0]    code;
  logic [3:0]    xoff;
  logic [3:0]    yoff;
  logic          active;
  logic          hs1;
  logic          vs1;
  logic          first1;

  assign pix_en = (div == DW'(CLKS_PER_PIXEL - 1));

  // Clock divider producing the pixel-rate strobe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (pix_en) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  // Stage 0: raster position counters, y steps when x wraps
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (pix_en) begin
      if (x == XW'(H_TOTAL - 1)) begin
        x <= '0;
        y <= (y == YW'(V_TOTAL - 1)) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // Stage 0 decode: visibility, raw syncs and character-cell address
  always_comb begin
    vis0      = (32'(x) < H_VISIBLE) && (32'(y) < V_VISIBLE);
    hs0       = !((32'(x) >= HS_START) && (32'(x) < HS_END));
    vs0       = !((32'(y) >= VS_START) && (32'(y) < VS_END));
    first0    = (x == '0) && (y == '0);
    row       = 11'(y >> 4);
    col       = 11'(x >> 4);
    // constant multiply reduces to shift-add; max cell index fits in 11 bits
    smem_addr = vis0 ? 11'(row * 11'(COLS) + col) : 11'd0;
  end

  // Stage 1: capture character code and the pixel's attributes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      code   <= '0;
      xoff   <= '0;
      yoff   <= '0;
      active <= 1'b0;
      hs1    <= 1'b1;
      vs1    <= 1'b1;
      first1 <= 1'b0;
    end else if (pix_en) begin
      code   <= smem_data;
      xoff   <= x[3:0];
      yoff   <= y[3:0];
      active <= vis0;
      hs1    <= hs0;
      vs1    <= vs0;
      first1 <= first0;
    end
  end

  assign bmem_addr = {code, yoff, xoff};

  // Stage 2: registered colour, syncs and the one-clock frame marker
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && first1;
      if (pix_en) begin
        {red, green, blue} <= active ? bmem_data : 12'h000;
        hsync              <= hs1;
        vsync              <= vs1;
      end
    end
  end

endmodule

// File: tb/tb_vga_text_display.sv
// Scoreboard bench for vga_text_display on a reduced raster geometry.
// Expected pixels come from absolute pixel index arithmetic over memory models.
module tb_vga_text_display;

  localparam int unsigned CPP   = 4;
  localparam int unsigned HV    = 48;
  localparam int unsigned HF    = 4;
  localparam int unsigned HS    = 8;
  localparam int unsigned HB    = 4;
  localparam int unsigned VV    = 40;
  localparam int unsigned VF    = 2;
  localparam int unsigned VS    = 2;
  localparam int unsigned VB    = 3;
  localparam int unsigned HT    = HV + HF + HS + HB;
  localparam int unsigned VT    = VV + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        pipe;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] smem_addr;
  logic [7:0]  smem_data;
  logic [15:0] bmem_addr;
  logic [11:0] bmem_data;
  logic        hsync;
  logic        vsync;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        frame_start;

  logic [7:0]  smem [0:2047];
  logic [11:0] bmem [0:65535];
  bit          fff_mode = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned edges;
  int          cyc = 0;
  exp_t        exp_q[$];

  assign smem_data = smem[smem_addr];
  assign bmem_data = fff_mode ? 12'hFFF : bmem[bmem_addr];

  vga_text_display #(
    .CLKS_PER_PIXEL(CPP),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .COLS(40)
  ) dut (
    .clock(clock), .reset(reset),
    .smem_addr(smem_addr), .smem_data(smem_data),
    .bmem_addr(bmem_addr), .bmem_data(bmem_data),
    .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  // Clock edges since reset release, and a free-running cycle count
  always @(posedge clock or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  function automatic int unsigned pos_x(input int unsigned p);
    return p % HT;
  endfunction

  function automatic int unsigned pos_y(input int unsigned p);
    return (p / HT) % VT;
  endfunction

  function automatic bit vis(input int unsigned p);
    return (pos_x(p) < HV) && (pos_y(p) < VV);
  endfunction

  function automatic logic [10:0] exp_saddr(input int unsigned p);
    return vis(p) ? 11'((pos_y(p) / 16) * 40 + pos_x(p) / 16) : 11'd0;
  endfunction

  // Glyph address seen while the raster sits at pixel p (belongs to pixel p-1)
  function automatic logic [15:0] exp_baddr(input int unsigned p);
    int unsigned q;
    logic [7:0]  c;
    q = p - 1;
    c = smem[exp_saddr(q)];
    return {c, 4'(pos_y(q) % 16), 4'(pos_x(q) % 16)};
  endfunction

  // Reference: queue the expected output for each new raster pixel
  int unsigned rp;
  int unsigned rx;
  int unsigned ry;
  exp_t        re;
  always @(negedge clock) begin
    if (!reset && (edges % CPP == 0)) begin
      rp      = edges / CPP;
      rx      = pos_x(rp);
      ry      = pos_y(rp);
      re.rgb  = vis(rp) ? (fff_mode ? 12'hFFF : bmem[exp_baddr(rp + 1)]) : 12'h000;
      re.hs   = !((rx >= HV + HF) && (rx < HV + HF + HS));
      re.vs   = !((ry >= VV + VF) && (ry < VV + VF + VS));
      re.fs   = (rx == 0) && (ry == 0);
      re.pipe = (rx == 17) && (ry == 35) && !fff_mode;
      exp_q.push_back(re);
    end
  end

  // Monitor: addresses against raster position, outputs against the scoreboard
  int unsigned mp;
  int unsigned mx;
  int unsigned my;
  exp_t        cur = '0;
  bit          popped;
  always @(negedge clock) begin
    if (!reset) begin
      mp = edges / CPP;
      mx = pos_x(mp);
      my = pos_y(mp);
      chk("smem_addr", 32'(smem_addr), 32'(exp_saddr(mp)));
      chk("bmem_addr", 32'(bmem_addr), (mp == 0) ? 32'd0 : 32'(exp_baddr(mp)));
      if (mx == 17 && my == 35)          chk("smem_addr_17_35", 32'(smem_addr), 32'd81);
      if (mx == HV - 1 && my == VV - 1)  chk("smem_addr_corner", 32'(smem_addr), 32'd82);
      if (mx == HV && my == 0)           chk("smem_addr_hblank", 32'(smem_addr), 32'd0);
      if (mx == 0 && my == VV)           chk("smem_addr_vblank", 32'(smem_addr), 32'd0);
      if (mp > 0 && pos_x(mp - 1) == 17 && pos_y(mp - 1) == 35)
        chk("bmem_addr_17_35", 32'(bmem_addr), 32'h4131);
      if (edges < 2 * CPP) begin
        chk("rgb_startup", 32'({red, green, blue}), 32'd0);
        chk("hsync_startup", 32'(hsync), 32'd1);
        chk("vsync_startup", 32'(vsync), 32'd1);
        chk("frame_start_startup", 32'(frame_start), 32'd0);
      end else begin
        popped = 1'b0;
        if (edges % CPP == 0) begin
          chk("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            cur    = exp_q.pop_front();
            popped = 1'b1;
          end
        end
        chk("rgb", 32'({red, green, blue}), 32'(cur.rgb));
        chk("hsync", 32'(hsync), 32'(cur.hs));
        chk("vsync", 32'(vsync), 32'(cur.vs));
        chk("frame_start", 32'(frame_start), popped ? 32'(cur.fs) : 32'd0);
        if (popped && cur.pipe) chk("pipe_rgb_17_35", 32'({red, green, blue}), 32'hABC);
      end
    end
  end

  // Timing monitor: sync and frame_start periods and widths in clocks
  int  hfall = -1;
  int  vfall = -1;
  int  frise = -1;
  bit  hs_q = 1'b1;
  bit  vs_q = 1'b1;
  bit  fs_q = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      hfall = -1; vfall = -1; frise = -1;
      hs_q = 1'b1; vs_q = 1'b1; fs_q = 1'b0;
    end else begin
      if (hs_q && !hsync) begin
        if (hfall >= 0) chk("hsync_period", 32'(cyc - hfall), 32'(HT * CPP));
        hfall = cyc;
      end
      if (!hs_q && hsync && hfall >= 0) chk("hsync_low", 32'(cyc - hfall), 32'(HS * CPP));
      if (vs_q && !vsync) begin
        if (vfall >= 0) chk("vsync_period", 32'(cyc - vfall), 32'(FRAME * CPP));
        vfall = cyc;
      end
      if (!vs_q && vsync && vfall >= 0) chk("vsync_low", 32'(cyc - vfall), 32'(VS * HT * CPP));
      if (!fs_q && frame_start) begin
        if (frise >= 0) chk("frame_start_period", 32'(cyc - frise), 32'(FRAME * CPP));
        frise = cyc;
      end
      if (fs_q && !frame_start && frise >= 0) chk("frame_start_width", 32'(cyc - frise), 32'd1);
      hs_q = hsync;
      vs_q = vsync;
      fs_q = frame_start;
    end
  end

  // Stimulus: memory contents, reset sequencing and glyph-mode switch
  initial begin
    for (int i = 0; i < 2048; i++) smem[i] = 8'($urandom);
    for (int i = 0; i < 65536; i++) bmem[i] = 12'($urandom);
    smem[0]        = 8'($urandom_range(1, 255));
    smem[81]       = 8'h41;
    bmem[16'h4131] = 12'hABC;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_hsync", 32'(hsync), 32'd1);
    chk("reset_vsync", 32'(vsync), 32'd1);
    chk("reset_rgb", 32'({red, green, blue}), 32'd0);
    chk("reset_smem_addr", 32'(smem_addr), 32'd0);
    chk("reset_bmem_addr", 32'(bmem_addr), 32'd0);
    chk("reset_frame_start", 32'(frame_start), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Run past one frame, then reset asynchronously mid-line
    repeat (FRAME * CPP + (10 * HT + 5 + $urandom_range(0, 30)) * CPP + $urandom_range(0, CPP - 1))
      @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_hsync", 32'(hsync), 32'd1);
    chk("async_vsync", 32'(vsync), 32'd1);
    chk("async_rgb", 32'({red, green, blue}), 32'd0);
    chk("async_smem_addr", 32'(smem_addr), 32'd0);
    chk("async_bmem_addr", 32'(bmem_addr), 32'd0);
    chk("async_frame_start", 32'(frame_start), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Switch the glyph model to all-ones while in vertical blanking
    repeat ((VV * HT + 5) * CPP) @(posedge clock);
    #1 fff_mode = 1'b1;
    repeat ((2 * FRAME + 100 - (VV * HT + 5)) * CPP) @(posedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
